score_display: RTL
==================

// Module: score_display
// PURPOSE
//  Consumer end of the 16-bit dino score bus, same clock domain as the score producer.
//  Tracks the binary score and converts it to 5 BCD digits with a sequential double-dabble.
//  Drives a time-multiplexed 5-digit 7-segment display.
//  Sits at the board or top level, between the score bus pins and the display.
// PARAMETERS
//  REFRESH_DIV     1000  clk cycles each digit stays selected (>=2)
//  LZ_BLANK        1     1 = blank leading zeros (digit0 always shown)
//  SEG_ACTIVE_LOW  0     1 = invert seg and dig_sel at the output registers
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst_n     in   1   synchronous, active-low reset
//  score     in   16  binary score, {hi byte, lo byte} as driven on the score bus
//  bcd_out   out  20  committed BCD value, digit4 (ten-thousands) in [19:16]
//  busy      out  1   conversion in progress
//  seg       out  7   segments; bit0=a .. bit6=g
//  dig_sel   out  5   one-hot digit enable; bit0 = units digit
// BEHAVIOUR
//  Reset values (active-high view, rst_n low at an edge):
//   - bcd_out = 0, busy = 0, last_conv = 0
//   - scan idx = 0, prescaler = 0
//   - seg = 7'h3F, dig_sel = 5'b00001
//  FSM IDLE -> CONV -> COMMIT -> IDLE:
//   - IDLE, edge E0, score != last_conv: capture score; clear BCD accumulator; go CONV; busy=1.
//   - CONV, edges E1..E16: one iteration per edge.
//     Each accumulator nibble >=5 gets +3, then {bcd,bin} <<= 1.
//   - COMMIT, edge E17: bcd_out <= accumulator; last_conv <= captured score; busy=0; go IDLE.
//   - Latency: bcd_out is valid after E17. busy is high for exactly 17 cycles.
//   - score changes while busy are ignored. IDLE re-compares on the next edge, so the final value
//     always converges. Intermediate values may be skipped.
//   - Steady score: no reconversion. score==0 after reset: no conversion (bcd_out already 0).
//  Arithmetic: 36-bit shift register {20 BCD, 16 bin}. Full range 0..65535 -> 20'h65535. No overflow.
//  Scan:
//   - Prescaler counts 0..REFRESH_DIV-1, then wraps.
//   - On wrap, idx increments; idx 4 wraps to 0.
//  Output registers (loaded every edge from current idx and bcd_out):
//   - seg = encode(digit[idx]); dig_sel = 1<<idx.
//   - This gives a 1-cycle lag vs idx and bcd_out.
//   - Encode table 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
//  Leading-zero blanking (LZ_BLANK=1):
//   - digit k>0 gives seg=0 when digits k..4 are all zero.
//   - dig_sel is still asserted for a blanked digit.
//  Reset mid-conversion abandons the conversion. All state returns to reset values on the same edge.
// STRUCTURE
//  Shared header score_pkg.vh holds:
//   - SCORE_W=16, NUM_DIGITS=5, BCD_W=20
//   - SEG_* encoding constants
//   - FSM state encodings ST_IDLE, ST_CONV, ST_COMMIT
//  Sub-module bin2bcd_seq: FSM, iteration counter, shift register, busy and bcd_out commit.
//  Top level holds: scan prescaler, digit mux, encoder, blanking, polarity.
// TESTING (REFRESH_DIV=4 unless stated)
//  1. Hold rst_n=0 for 2 cycles -> seg=7'h3F, dig_sel=5'b00001, bcd_out=0, busy=0.
//     Then score stays 0 -> busy never rises.
//  2. score=16'd12345 at E0 -> busy=1 during E1..E17; after E17 bcd_out=20'h12345.
//     Over a scan, seg cycles 6D,66,4F,5B,06.
//  3. score=16'hFFFF -> bcd_out=20'h65535 after 17 cycles. Then score=0 -> bcd_out=0 after 17 more.
//  4. score=7, LZ_BLANK=1 -> digit0 seg=7'h07, digits1..4 seg=0.
//     Same with LZ_BLANK=0 -> digits1..4 seg=7'h3F.
//  5. score=100, then 200 at cycle 5 of the conversion -> bcd_out=20'h00100 at E17.
//     Then 20'h00200 at E35.
//  6. rst_n=0 mid-CONV (cycle 8), score=300 -> busy=0, bcd_out=0.
//     After release, bcd_out=20'h00300 18 cycles later.
//     Also check the scan wraps dig_sel 5'b10000 -> 5'b00001.

Source files
------------

// File: rtl/score_display_pkg.sv
// score_display_pkg: shared widths, segment codes, FSM encodings and double-dabble step.
package score_display_pkg;
    localparam int SCORE_W    = 16;
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 20;
    localparam int SR_W       = BCD_W + SCORE_W;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration on {bcd, bin}: add 3 to nibbles >= 5, then shift left.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] a;
        a = sr;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (a[SCORE_W+4*k +: 4] >= 4'd5) a[SCORE_W+4*k +: 4] = a[SCORE_W+4*k +: 4] + 4'd3;
        return a << 1;
    endfunction
endpackage

// File: rtl/score_display_if.sv
// score_display_if: score bus input plus the BCD and display outputs of the score display.
interface score_display_if;
    import score_display_pkg::*;
    logic [SCORE_W-1:0] score;
    logic [BCD_W-1:0]   bcd_out;
    logic               busy;
    logic [6:0]         seg;
    logic [4:0]         dig_sel;
    modport master (output score, input bcd_out, busy, seg, dig_sel);
    modport slave  (input score, output bcd_out, busy, seg, dig_sel);
endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// score_display_bin2bcd_seq: sequential double-dabble, one bit per clock, commits on change.
module score_display_bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    output logic [BCD_W-1:0]   bcd_out,
    output logic               busy
);
    logic [1:0]         state;
    logic [3:0]         iter;
    logic [SR_W-1:0]    sr;
    logic [SCORE_W-1:0] cap;
    logic [SCORE_W-1:0] last_conv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            iter      <= '0;
            sr        <= '0;
            cap       <= '0;
            last_conv <= '0;
            bcd_out   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (score != last_conv) begin
                    cap   <= score;
                    sr    <= {{BCD_W{1'b0}}, score};
                    iter  <= '0;
                    busy  <= 1'b1;
                    state <= ST_CONV;
                end
                ST_CONV: begin
                    sr    <= dd_step(sr);
                    iter  <= iter + 4'd1;
                    state <= iter == 4'd15 ? ST_COMMIT : ST_CONV;
                end
                ST_COMMIT: begin
                    bcd_out   <= sr[SR_W-1 -: BCD_W];
                    last_conv <= cap;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/score_display.sv
// score_display: binary score to BCD, scanned onto a 5-digit multiplexed 7-segment display.
module score_display
    import score_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter bit LZ_BLANK       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
)(
    input logic             clk,
    input logic             rst_n,
    score_display_if.slave  bus
);
    localparam int            PW      = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [4:0]    SEL_INV = {5{SEG_ACTIVE_LOW}};

    logic [BCD_W-1:0] bcd;
    logic             busy;
    logic [PW-1:0]    pre;
    logic [2:0]       idx;
    logic [3:0]       digit;
    logic [6:0]       seg_n;
    logic [4:0]       sel_n;
    logic [6:0]       seg_q;
    logic [4:0]       sel_q;

    score_display_bin2bcd_seq u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .score   (bus.score),
        .bcd_out (bcd),
        .busy    (busy)
    );

    // A digit above the units is blank when it and every higher digit are zero.
    assign digit = bcd[{idx, 2'b00} +: 4];
    assign seg_n = (LZ_BLANK && idx != 3'd0 && (bcd >> {idx, 2'b00}) == '0) ? SEG_BLANK : seg_encode(digit);
    assign sel_n = 5'b00001 << idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre   <= '0;
            idx   <= '0;
            seg_q <= SEG_0 ^ SEG_INV;
            sel_q <= 5'b00001 ^ SEL_INV;
        end else begin
            pre   <= pre == PRE_MAX ? '0 : pre + PW'(1);
            idx   <= pre != PRE_MAX ? idx : idx == 3'd4 ? 3'd0 : idx + 3'd1;
            seg_q <= seg_n ^ SEG_INV;
            sel_q <= sel_n ^ SEL_INV;
        end
    end

    assign bus.bcd_out = bcd;
    assign bus.busy    = busy;
    assign bus.seg     = seg_q;
    assign bus.dig_sel = sel_q;
endmodule
